// File: rtl/dds_mod_engine.sv
// Multi-channel DDS with LFSR-keyed ASK/FSK/BPSK modulation.
// Each accepted sample tick advances every phase accumulator, then streams one sample per channel.
module dds_mod_engine #(
   parameter int unsigned PHASE_W = 32,
   parameter int unsigned OUT_W   = 12,
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned LFSR_W  = 5,
   localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sample_tick,
   input  logic               lfsr_tick,
   input  logic [1:0]         mod_sel,
   input  logic [1:0]         wave_sel,
   input  logic               cfg_we,
   input  logic               cfg_alt,
   input  logic [CH_W-1:0]    cfg_ch,
   input  logic [PHASE_W-1:0] cfg_incr,
   input  logic               ovr_clr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CH_W-1:0]    out_ch,
   output logic [OUT_W-1:0]   out_data,
   output logic               overrun,
   output logic [LFSR_W-1:0]  lfsr_val
);

   typedef enum logic [0:0] {StIdle, StEmit} state_e;

   localparam logic [1:0] ModAsk  = 2'd1;
   localparam logic [1:0] ModFsk  = 2'd2;
   localparam logic [1:0] ModBpsk = 2'd3;

   localparam logic [OUT_W-1:0] MinVal = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] MaxVal = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] NegMax = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
   localparam logic [CH_W-1:0]  LastCh = CH_W'(NUM_CH - 1);

   state_e              state_q, state_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [PHASE_W-1:0]  phase_q [NUM_CH];
   logic [PHASE_W-1:0]  incr_q  [NUM_CH];
   logic [PHASE_W-1:0]  alt_q   [NUM_CH];
   logic [1:0]          mod_q, wave_q;
   logic                bit_q;
   logic                ovr_q;
   logic                ltick_q, ltick_qq;
   logic [LFSR_W-1:0]   lfsr_q;
   logic                tick_acc, tick_busy, use_alt;

   assign tick_acc  = sample_tick && (state_q == StIdle);
   assign tick_busy = sample_tick && (state_q != StIdle);
   assign use_alt   = (mod_sel == ModFsk) && lfsr_q[0];

   // Increment registers update with NBAs, so a coincident tick sees the old value.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            phase_q[c] <= '0;
            incr_q[c]  <= '0;
            alt_q[c]   <= '0;
         end
         mod_q  <= '0;
         wave_q <= '0;
         bit_q  <= 1'b0;
      end else begin
         if (tick_acc) begin
            for (int c = 0; c < NUM_CH; c++) begin
               phase_q[c] <= phase_q[c] + (use_alt ? alt_q[c] : incr_q[c]);
            end
            mod_q  <= mod_sel;
            wave_q <= wave_sel;
            bit_q  <= lfsr_q[0];
         end
         if (cfg_we) begin
            if (cfg_alt) alt_q[cfg_ch]  <= cfg_incr;
            else         incr_q[cfg_ch] <= cfg_incr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         ch_q    <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      out_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (sample_tick) begin
               state_d = StEmit;
               ch_d    = '0;
            end
         end
         StEmit: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (ch_q == LastCh) begin
                  state_d = StIdle;
                  ch_d    = '0;
               end else begin
                  ch_d = ch_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)          ovr_q <= 1'b0;
      else if (tick_busy) ovr_q <= 1'b1;
      else if (ovr_clr)   ovr_q <= 1'b0;
   end

   // Edge detect on the registered copy so a held level advances only once.
   always_ff @(posedge clk) begin
      if (reset) begin
         ltick_q  <= 1'b0;
         ltick_qq <= 1'b0;
         lfsr_q   <= LFSR_W'(1);
      end else begin
         ltick_q  <= lfsr_tick;
         ltick_qq <= ltick_q;
         if (ltick_q && !ltick_qq) begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2], lfsr_q[LFSR_W-1:1]};
         end
      end
   end

   logic [OUT_W-1:0] p, t, wave, modv;

   always_comb begin
      p = phase_q[ch_q][PHASE_W-1 -: OUT_W];
      t = '0;
      t[OUT_W-2:0] = p[OUT_W-1] ? ~p[OUT_W-2:0] : p[OUT_W-2:0];
      case (wave_q)
         2'd0:    wave = p - MinVal;
         2'd1:    wave = p[OUT_W-1] ? NegMax : MaxVal;
         default: wave = {t[OUT_W-2:0], 1'b0} - MinVal;
      endcase
      modv = wave;
      if (mod_q == ModAsk && !bit_q) begin
         modv = '0;
      end else if (mod_q == ModBpsk && bit_q) begin
         modv = (wave == MinVal) ? MaxVal : (~wave + 1'b1);
      end
   end

   assign out_data = (state_q == StEmit) ? modv : '0;
   assign out_ch   = ch_q;
   assign overrun  = ovr_q;
   assign lfsr_val = lfsr_q;

endmodule

// File: tb/tb_dds_mod_engine.sv
// Bench for dds_mod_engine: event-level model with an expected-sample queue, checked every cycle,
// plus directed scenarios pinned by literal expected samples.
module tb_dds_mod_engine;

   localparam int PW = 32;
   localparam int OW = 12;
   localparam int NC = 4;
   localparam int LW = 5;
   localparam int CW = 2;
   localparam int M  = 2048;

   logic          clk = 1'b0;
   logic          reset, sample_tick, lfsr_tick, cfg_we, cfg_alt, ovr_clr, out_ready;
   logic [1:0]    mod_sel, wave_sel;
   logic [CW-1:0] cfg_ch;
   logic [PW-1:0] cfg_incr;
   logic          out_valid, overrun;
   logic [CW-1:0] out_ch;
   logic [OW-1:0] out_data;
   logic [LW-1:0] lfsr_val;

   dds_mod_engine #(.PHASE_W(PW), .OUT_W(OW), .NUM_CH(NC), .LFSR_W(LW)) dut (
      .clk(clk), .reset(reset), .sample_tick(sample_tick), .lfsr_tick(lfsr_tick),
      .mod_sel(mod_sel), .wave_sel(wave_sel), .cfg_we(cfg_we), .cfg_alt(cfg_alt),
      .cfg_ch(cfg_ch), .cfg_incr(cfg_incr), .ovr_clr(ovr_clr), .out_valid(out_valid),
      .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data), .overrun(overrun),
      .lfsr_val(lfsr_val)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ch;
      int data;
   } samp_t;

   samp_t       exp_q[$];
   samp_t       cap_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] ph_m [NC];
   logic [31:0] inc_m [NC];
   logic [31:0] alt_m [NC];
   logic [4:0]  lfsr_m;
   bit          r1, r2, ovr_m;
   bit          started = 0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Sample value straight from the waveform/modulation definitions, in plain integers.
   function automatic int shape(input logic [31:0] ph, input logic [1:0] w, input logic [1:0] md,
                                input bit b);
      int p, v;
      p = int'(ph >> (PW - OW));
      case (w)
         2'd0:    v = p - M;
         2'd1:    v = (p >= M) ? -(M - 1) : (M - 1);
         default: v = (p < M) ? 2 * p - M : 2 * (2 * M - 1 - p) - M;
      endcase
      if (md == 2'd1 && !b) v = 0;
      if (md == 2'd3 && b) v = (v == -M) ? M - 1 : -v;
      return v;
   endfunction

   always @(posedge clk) begin
      bit busy, b;
      busy = exp_q.size() != 0;
      started = 1;
      if (reset) begin
         exp_q.delete();
         for (int c = 0; c < NC; c++) begin
            ph_m[c] = 0; inc_m[c] = 0; alt_m[c] = 0;
         end
         lfsr_m = 5'd1; r1 = 0; r2 = 0; ovr_m = 0;
      end else begin
         if (busy && out_ready) void'(exp_q.pop_front());
         if (sample_tick && busy) ovr_m = 1;
         else if (ovr_clr) ovr_m = 0;
         if (sample_tick && !busy) begin
            b = lfsr_m[0];
            for (int c = 0; c < NC; c++) begin
               ph_m[c] = ph_m[c] + ((mod_sel == 2'd2 && b) ? alt_m[c] : inc_m[c]);
               exp_q.push_back('{ch: c, data: shape(ph_m[c], wave_sel, mod_sel, b)});
            end
         end
         if (cfg_we) begin
            if (cfg_alt) alt_m[cfg_ch] = cfg_incr;
            else         inc_m[cfg_ch] = cfg_incr;
         end
         if (r1 && !r2) lfsr_m = {lfsr_m[0] ^ lfsr_m[2], lfsr_m[4:1]};
         r2 = r1;
         r1 = lfsr_tick;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            chk("out_ch", int'(out_ch), exp_q[0].ch);
            chk("out_data", int'($signed(out_data)), exp_q[0].data);
         end
         chk("overrun", int'(overrun), int'(ovr_m));
         chk("lfsr_val", int'(lfsr_val), int'(lfsr_m));
         if (out_valid && out_ready) cap_q.push_back('{ch: int'(out_ch), data: int'($signed(out_data))});
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick(input logic [1:0] md, input logic [1:0] w);
      cyc(1);
      sample_tick = 1; mod_sel = md; wave_sel = w;
      cyc(1);
      sample_tick = 0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         cyc(1);
         n++;
      end
      if (n >= 100) chk("drain_timeout", n, 0);
   endtask

   task automatic cfg(input int ch, input bit alt, input logic [31:0] val);
      cyc(1);
      cfg_we = 1; cfg_alt = alt; cfg_ch = CW'(ch); cfg_incr = val;
      cyc(1);
      cfg_we = 0;
   endtask

   task automatic do_reset();
      cyc(1);
      reset = 1;
      cyc(2);
      reset = 0;
   endtask

   task automatic toggle_lfsr();
      cyc(1);
      lfsr_tick = 1;
      cyc(2);
      lfsr_tick = 0;
      cyc(2);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int exp0 [4];
      exp0[0] = -1024; exp0[1] = 0; exp0[2] = 1024; exp0[3] = -2048;
      reset = 1; sample_tick = 0; lfsr_tick = 0; cfg_we = 0; cfg_alt = 0; ovr_clr = 0;
      out_ready = 1; mod_sel = 0; wave_sel = 0; cfg_ch = 0; cfg_incr = 0;

      // Reset state
      cyc(3);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_lfsr", int'(lfsr_val), 1);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_data", int'(out_data), 0);
      reset = 0;

      // Sawtooth on channel 0, other channels idle at phase 0
      cfg(0, 0, 32'h4000_0000);
      cap_q.delete();
      for (int k = 0; k < 4; k++) begin
         tick(2'd0, 2'd0);
         drain();
      end
      cyc(1);
      chk("saw_count", cap_q.size(), 16);
      if (cap_q.size() == 16) begin
         for (int i = 0; i < 16; i++) begin
            chk("saw_ch", cap_q[i].ch, i % 4);
            chk("saw_data", cap_q[i].data, (i % 4 == 0) ? exp0[i / 4] : -2048);
         end
      end

      // Backpressure, overrun and its clear
      out_ready = 0;
      tick(2'd0, 2'd0);
      cyc(5);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_ch", int'(out_ch), 0);
      chk("stall_data", int'($signed(out_data)), -1024);
      tick(2'd0, 2'd0);
      chk("ovr_set", int'(overrun), 1);
      sample_tick = 1; ovr_clr = 1;
      cyc(1);
      sample_tick = 0;
      chk("ovr_set_wins", int'(overrun), 1);
      cyc(1);
      ovr_clr = 0;
      chk("ovr_clr", int'(overrun), 0);
      out_ready = 1;
      drain();
      cap_q.delete();
      tick(2'd0, 2'd0);
      drain();
      cyc(1);
      chk("no_advance_ch0", (cap_q.size() > 0) ? cap_q[0].data : 9999, 0);

      // LFSR period and level-held behaviour
      for (int i = 0; i < 31; i++) begin
         toggle_lfsr();
         if (i == 0) chk("lfsr_first", int'(lfsr_val), 16);
      end
      chk("lfsr_period", int'(lfsr_val), 1);
      cyc(1);
      lfsr_tick = 1;
      cyc(10);
      lfsr_tick = 0;
      cyc(3);
      chk("lfsr_held", int'(lfsr_val), 16);

      // Square/triangle with BPSK and ASK at phase 0
      do_reset();
      cap_q.delete();
      tick(2'd3, 2'd1);
      drain();
      tick(2'd3, 2'd2);
      drain();
      toggle_lfsr();
      tick(2'd3, 2'd1);
      drain();
      tick(2'd1, 2'd1);
      drain();
      cyc(1);
      chk("mod_count", cap_q.size(), 16);
      if (cap_q.size() == 16) begin
         chk("bpsk_b1", cap_q[0].data, -2047);
         chk("bpsk_sat", cap_q[4].data, 2047);
         chk("bpsk_b0", cap_q[8].data, 2047);
         chk("ask_b0", cap_q[12].data, 0);
      end

      // FSK alternate increment, config write coincident with tick
      do_reset();
      cfg(0, 0, 32'h1000_0000);
      cfg(0, 1, 32'h2000_0000);
      cap_q.delete();
      tick(2'd2, 2'd0);
      drain();
      cyc(1);
      sample_tick = 1; mod_sel = 0; wave_sel = 0;
      cfg_we = 1; cfg_alt = 0; cfg_ch = 0; cfg_incr = 32'h3000_0000;
      cyc(1);
      sample_tick = 0; cfg_we = 0;
      drain();
      tick(2'd0, 2'd0);
      drain();
      cyc(1);
      chk("fsk_count", cap_q.size(), 12);
      if (cap_q.size() == 12) begin
         chk("fsk_alt", cap_q[0].data, -1536);
         chk("cfg_old", cap_q[4].data, -1280);
         chk("cfg_new", cap_q[8].data, -512);
      end

      // Reset in the middle of a burst
      out_ready = 0;
      tick(2'd0, 2'd0);
      cyc(2);
      do_reset();
      chk("abort_valid", int'(out_valid), 0);
      out_ready = 1;
      cap_q.delete();
      tick(2'd0, 2'd0);
      drain();
      cyc(1);
      chk("post_abort_count", cap_q.size(), 4);
      if (cap_q.size() == 4) chk("post_abort_data", cap_q[0].data, -2048);

      cyc(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
